// File: rtl/snake_render_pkg.sv
// snake_render_pkg: shared FSM type, tile colours and width helpers for the snake renderer
package snake_render_pkg;
    typedef enum logic [1:0] {IDLE, DIV, SCAN, COMMIT} state_t;
    localparam logic [11:0] HEAD_COLOR = 12'h0F0;
    localparam logic [11:0] BODY_COLOR = 12'h080;
    localparam logic [11:0] FOOD_COLOR = 12'hF00;
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/tile_divider.sv
// tile_divider: divides by a constant with one subtraction per cycle; quotient saturates at Q_MAX
module tile_divider
    import snake_render_pkg::*;
#(
    parameter int W       = 10,
    parameter int DIVISOR = 48,
    parameter int Q_MAX   = 8,
    parameter int Q_W     = cnt_w(Q_MAX)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   dividend,
    output logic [Q_W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           done
);
    logic running;
    logic step;
    assign step = (remainder >= W'(DIVISOR)) && (quotient < Q_W'(Q_MAX));
    assign done = running && !step;
    // Load on start, then peel one divisor per cycle until the remainder is below it or the quotient saturates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            running   <= 1'b1;
            quotient  <= '0;
            remainder <= dividend;
        end else if (running) begin
            running <= step;
            if (step) begin
                quotient  <= quotient + Q_W'(1);
                remainder <= remainder - W'(DIVISOR);
            end
        end
    end
endmodule

// File: rtl/snake_tile_renderer.sv
// snake_tile_renderer: overlays snake body, head and food tiles on the background using per-row masks built during blanking
module snake_tile_renderer
    import snake_render_pkg::*;
#(
    parameter int MAX_LEN   = 100,
    parameter int COORD_W   = 32,
    parameter int GRID_W    = 8,
    parameter int GRID_H    = 8,
    parameter int TILE_SIZE = 48,
    parameter int BOX_SIZE  = 40,
    parameter int BOARD_X0  = 48,
    parameter int BOARD_Y0  = 48
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pix_en,
    input  logic                           frame_start,
    input  logic                           line_start,
    input  logic [9:0]                     line_y,
    input  logic [9:0]                     pixel_x,
    input  logic                           active,
    input  logic [$clog2(MAX_LEN+1)-1:0]   snake_len,
    input  logic [MAX_LEN*COORD_W-1:0]     x_values,
    input  logic [MAX_LEN*COORD_W-1:0]     y_values,
    input  logic [COORD_W-1:0]             food_x,
    input  logic [COORD_W-1:0]             food_y,
    input  logic [11:0]                    bg_color,
    output logic [11:0]                    color_out,
    output logic                           busy,
    output logic                           overrun
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int COL_W = idx_w(GRID_W);
    localparam int CC_W  = cnt_w(GRID_W);
    localparam int OFF_W = idx_w(TILE_SIZE);
    localparam int TR_W  = cnt_w(GRID_H);

    state_t state, next_state;
    logic [LEN_W-1:0]   len_s, idx;
    logic [COORD_W-1:0] xs [MAX_LEN];
    logic [COORD_W-1:0] ys [MAX_LEN];
    logic [COORD_W-1:0] food_xs, food_ys, cur_x, cur_y;
    logic [TR_W-1:0]    tile_row, div_q;
    logic [9:0]         pend_y, y_in, div_r;
    logic               row_valid, pend, go, above, div_start, div_done, row_ok, last, hit;
    logic [GRID_W-1:0]  mask_next, head_next, mask_cur, head_cur;
    logic               food_on;
    logic [COL_W-1:0]   food_col, c;
    logic [CC_W-1:0]    col, eff_col;
    logic [OFF_W-1:0]   off, eff_off;
    logic               at_x0, in_col;
    logic [11:0]        sel;

    assign go        = line_start || pend;
    assign y_in      = line_start ? line_y : pend_y;
    assign above     = y_in < 10'(BOARD_Y0);
    assign div_start = (state == IDLE) && go && !above;
    assign row_ok    = (div_q < TR_W'(GRID_H)) && (div_r < 10'(BOX_SIZE));
    assign cur_x     = xs[idx];
    assign cur_y     = ys[idx];
    assign hit       = (cur_y == COORD_W'(tile_row)) && (cur_x < COORD_W'(GRID_W));
    assign last      = idx == len_s - LEN_W'(1);

    tile_divider #(
        .W       (10),
        .DIVISOR (TILE_SIZE),
        .Q_MAX   (GRID_H),
        .Q_W     (TR_W)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (y_in - 10'(BOARD_Y0)),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done)
    );

    // Frame snapshot so every line of a frame renders from the same snake state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_s   <= '0;
            food_xs <= '0;
            food_ys <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else if (frame_start) begin
            len_s   <= (snake_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : snake_len;
            food_xs <= food_x;
            food_ys <= food_y;
            for (int i = 0; i < MAX_LEN; i++) begin
                xs[i] <= x_values[i*COORD_W +: COORD_W];
                ys[i] <= y_values[i*COORD_W +: COORD_W];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next state; a new line_start mid-scan aborts straight to COMMIT
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (go) next_state = above ? COMMIT : DIV;
            DIV:     if (line_start) next_state = COMMIT;
                     else if (div_done) next_state = (row_ok && len_s != '0) ? SCAN : COMMIT;
            SCAN:    if (line_start || last) next_state = COMMIT;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs
    always_comb busy = (state == DIV) || (state == SCAN);

    // Row scan datapath: build next-row masks, then swap them into the display buffer at COMMIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            tile_row  <= '0;
            row_valid <= 1'b0;
            pend      <= 1'b0;
            pend_y    <= '0;
            overrun   <= 1'b0;
            mask_next <= '0;
            head_next <= '0;
            mask_cur  <= '0;
            head_cur  <= '0;
            food_on   <= 1'b0;
            food_col  <= '0;
        end else begin
            overrun <= overrun || (line_start && busy);
            pend    <= (state != IDLE) && (pend || line_start);
            if (line_start && state != IDLE) pend_y <= line_y;
            case (state)
                IDLE: if (go) row_valid <= !above;
                DIV: begin
                    if (line_start) row_valid <= 1'b0;
                    else if (div_done) begin
                        row_valid <= row_ok;
                        tile_row  <= div_q;
                        idx       <= '0;
                    end
                end
                SCAN: begin
                    if (line_start) row_valid <= 1'b0;
                    else begin
                        if (hit) mask_next[cur_x[COL_W-1:0]] <= 1'b1;
                        if (hit && idx == '0) head_next[cur_x[COL_W-1:0]] <= 1'b1;
                        idx <= idx + LEN_W'(1);
                    end
                end
                default: begin
                    mask_cur  <= row_valid ? mask_next : '0;
                    head_cur  <= row_valid ? head_next : '0;
                    food_on   <= row_valid && (food_ys == COORD_W'(tile_row)) && (food_xs < COORD_W'(GRID_W));
                    food_col  <= food_xs[COL_W-1:0];
                    mask_next <= '0;
                    head_next <= '0;
                end
            endcase
        end
    end

    assign at_x0   = pixel_x == 10'(BOARD_X0);
    assign eff_col = at_x0 ? '0 : col;
    assign eff_off = at_x0 ? '0 : off;
    assign in_col  = (eff_col < CC_W'(GRID_W)) && (int'(eff_off) < BOX_SIZE) && (pixel_x >= 10'(BOARD_X0));
    assign c       = eff_col[COL_W-1:0];

    // Column tracker holds the tile position of the next pixel; column saturates past the board
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= CC_W'(GRID_W);
            off <= '0;
        end else if (pix_en) begin
            off <= (eff_off == OFF_W'(TILE_SIZE - 1)) ? '0 : eff_off + OFF_W'(1);
            col <= (eff_off == OFF_W'(TILE_SIZE - 1) && eff_col != CC_W'(GRID_W)) ? eff_col + CC_W'(1) : eff_col;
        end
    end

    // Colour priority: head over body over food over background
    always_comb sel = !in_col ? bg_color :
                      head_cur[c] ? HEAD_COLOR :
                      mask_cur[c] ? BODY_COLOR :
                      (food_on && food_col == c) ? FOOD_COLOR : bg_color;

    // Registered pixel output, black outside the visible region
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) color_out <= '0;
        else        color_out <= active ? sel : 12'h000;
    end
endmodule

// File: tb/tb_snake_tile_renderer.sv
// tb_snake_tile_renderer: directed and randomized frames checked against a tile-geometry reference model
module tb_snake_tile_renderer;
    localparam int MAX_LEN = 100, CW = 32, GW = 8, GH = 8, TS = 48, BS = 40, X0 = 48, Y0 = 48;

    logic clk = 0, reset = 0, pix_en = 0, frame_start = 0, line_start = 0, active = 0;
    logic [9:0] line_y = '0, pixel_x = '0;
    logic [6:0] snake_len = '0;
    logic [MAX_LEN*CW-1:0] x_values = '0, y_values = '0;
    logic [CW-1:0] food_x = '0, food_y = '0;
    logic [11:0] bg_color = '0;
    logic [11:0] color_out;
    logic busy, overrun;

    int checks = 0, errors = 0;
    int sx[MAX_LEN], sy[MAX_LEN], slen, sfx, sfy;
    int mx[MAX_LEN], my[MAX_LEN], mlen, mfx, mfy;
    int n, r, y1;

    always #5 clk = ~clk;

    snake_tile_renderer dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .frame_start(frame_start),
        .line_start(line_start), .line_y(line_y), .pixel_x(pixel_x), .active(active),
        .snake_len(snake_len), .x_values(x_values), .y_values(y_values),
        .food_x(food_x), .food_y(food_y), .bg_color(bg_color),
        .color_out(color_out), .busy(busy), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_color(int px, int py, logic [11:0] bg, bit act, bit ns);
        int cc, rr;
        bit head, body;
        if (!act) return 12'h000;
        if (ns || px < X0 || py < Y0) return bg;
        if ((px - X0) % TS >= BS || (py - Y0) % TS >= BS) return bg;
        cc = (px - X0) / TS;
        rr = (py - Y0) / TS;
        if (cc >= GW || rr >= GH) return bg;
        head = mlen > 0 && mx[0] == cc && my[0] == rr;
        body = 0;
        for (int i = 0; i < mlen; i++) if (mx[i] == cc && my[i] == rr) body = 1;
        if (head) return 12'h0F0;
        if (body) return 12'h080;
        if (mfx == cc && mfy == rr) return 12'hF00;
        return bg;
    endfunction

    task automatic drive_coords();
        snake_len = 7'(slen);
        for (int i = 0; i < MAX_LEN; i++) begin
            x_values[i*CW +: CW] = sx[i];
            y_values[i*CW +: CW] = sy[i];
        end
        food_x = sfx;
        food_y = sfy;
    endtask

    task automatic load_frame(input bit with_line, input int y);
        drive_coords();
        @(negedge clk);
        frame_start = 1;
        if (with_line) begin
            line_y = 10'(y);
            line_start = 1;
        end
        mlen = slen > MAX_LEN ? MAX_LEN : slen;
        for (int i = 0; i < MAX_LEN; i++) begin
            mx[i] = sx[i];
            my[i] = sy[i];
        end
        mfx = sfx;
        mfy = sfy;
        @(negedge clk);
        frame_start = 0;
        line_start = 0;
    endtask

    task automatic randomize_snake(input int len, input int cmax);
        slen = len;
        for (int i = 0; i < MAX_LEN; i++) begin
            sx[i] = $urandom_range(0, cmax);
            sy[i] = $urandom_range(0, cmax);
        end
        sfx = $urandom_range(0, cmax);
        sfy = $urandom_range(0, cmax);
    endtask

    task automatic pulse_line(input int y);
        @(negedge clk);
        line_y = 10'(y);
        line_start = 1;
        @(negedge clk);
        line_start = 0;
    endtask

    task automatic wait_scan(output int cnt);
        cnt = 0;
        while (busy && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        check("scan_completes", cnt < 300, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic sweep(input int py, input int lo, input int hi, input bit ns, input string tag);
        for (int px = lo; px <= hi; px++) begin
            logic [11:0] bg;
            bit act;
            @(negedge clk);
            bg = 12'($urandom);
            act = px < 440;
            pixel_x = 10'(px);
            bg_color = bg;
            active = act;
            pix_en = 1;
            @(posedge clk);
            #1;
            check(tag, color_out, exp_color(px, py, bg, act, ns));
        end
        @(negedge clk);
        pix_en = 0;
        active = 0;
    endtask

    task automatic render(input int y, input string tag);
        int cnt;
        pulse_line(y);
        wait_scan(cnt);
        sweep(y, 0, 447, 0, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_color", color_out, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        reset = 1;

        // Empty snake, food off board: background only
        randomize_snake(0, 7);
        sfx = 9; sfy = 9;
        load_frame(0, 0);
        render(10, "len0_above");
        render(60, "len0_row0");
        render(200, "len0_row3");

        // Three-segment snake on row 1
        randomize_snake(3, 9);
        sx[0] = 2; sy[0] = 1; sx[1] = 1; sy[1] = 1; sx[2] = 0; sy[2] = 1;
        sfx = 5; sfy = 5;
        load_frame(0, 0);
        render(96, "len3_row1_top");
        render(120, "len3_row1_mid");
        render(135, "len3_row1_last");
        render(136, "len3_row_gap");
        render(288, "len3_food_row");
        render(60, "len3_row0");

        // Head overlapping its own body
        randomize_snake(6, 9);
        sx[0] = 3; sy[0] = 3; sx[2] = 3; sy[2] = 3;
        load_frame(0, 0);
        render(197, "overlap");

        // Mid-frame coordinate change must not show until the next frame_start
        randomize_snake(6, 7);
        drive_coords();
        render(197, "no_tearing");
        load_frame(1, 197);
        wait_scan(n);
        sweep(197, 0, 447, 0, "frame_and_line");

        // Overrun: second line_start 20 cycles into a long scan
        check("overrun_pre", overrun, 0);
        randomize_snake(100, 7);
        r = $urandom_range(0, 7);
        sx[0] = 0; sy[0] = r; sx[1] = 1; sy[1] = r;
        load_frame(0, 0);
        y1 = Y0 + r * TS + 2;
        pulse_line(y1);
        repeat (19) @(negedge clk);
        pulse_line(y1 + 1);
        check("overrun_set", overrun, 1);
        @(negedge clk);
        sweep(y1, 48, 143, 1, "aborted_line");
        wait_scan(n);
        sweep(y1 + 1, 0, 447, 0, "after_overrun");
        check("overrun_sticky", overrun, 1);

        // Clamped length and an off-grid column that would alias to column 0
        randomize_snake(120, 7);
        sx[5] = 8; sy[5] = 4;
        for (int i = 0; i < MAX_LEN; i++) if (i != 5 && sx[i] == 0 && sy[i] == 4) sx[i] = 1;
        sfx = 6;
        load_frame(0, 0);
        for (int k = 0; k < 3; k++) begin
            r = (k == 0) ? 4 : $urandom_range(0, 8);
            y1 = Y0 + r * TS + $urandom_range(0, 47);
            pulse_line(y1);
            wait_scan(n);
            check("busy_bound", n <= 110, 1);
            sweep(y1, 0, 447, 0, "clamp_len");
        end

        // Random frames
        for (int it = 0; it < 4; it++) begin
            randomize_snake($urandom_range(0, 127), 9);
            y1 = Y0 + $urandom_range(0, 8) * TS + $urandom_range(0, 47);
            load_frame(it % 2 == 1, y1);
            if (it % 2 == 1) begin
                wait_scan(n);
                sweep(y1, 0, 447, 0, "rand_coincident");
            end
            for (int k = 0; k < 2; k++) render($urandom_range(0, 479), "rand_row");
        end

        // Reset mid-scan clears masks, busy and overrun immediately
        randomize_snake(100, 7);
        for (int i = 0; i < GW; i++) begin
            sx[i] = i; sy[i] = 2;
        end
        load_frame(0, 0);
        render(Y0 + 2 * TS + 1, "pre_reset");
        pulse_line(Y0 + 2 * TS + 1);
        repeat (5) @(negedge clk);
        reset = 0;
        #1;
        check("reset_mid_busy", busy, 0);
        check("reset_mid_overrun", overrun, 0);
        @(negedge clk);
        reset = 1;
        sweep(Y0 + 2 * TS + 1, 0, 447, 1, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_tile_renderer.md
# snake_tile_renderer

- Renders the whole snake, not just the head, plus one food tile, over the background image colour in the VGA pixel path.
- Sits between the VGA timing generator/image palette output and the `{VGA_R,VGA_G,VGA_B}` assignment.
- Generalised in snake length, grid size and tile geometry.
- During each horizontal blanking it scans the segment list for the upcoming row into a double-buffered row mask, so per-pixel work is one mask lookup instead of MAX_LEN comparators.

## Interface
Parameters:
- MAX_LEN, 100: segment slots in packed coordinate arrays
- COORD_W, 32: bits per segment coordinate (tile units)
- GRID_W, 8: board columns
- GRID_H, 8: board rows
- TILE_SIZE, 48: tile pitch in pixels
- BOX_SIZE, 40: drawn square per tile (≤ TILE_SIZE)
- BOARD_X0, 48: first board pixel column
- BOARD_Y0, 48: first board pixel row

Ports (one clock, `clk`; reset is asynchronous, active-low, named `reset`):
- clk  in  1  system clock
- reset  in  1  async active-low reset
- pix_en  in  1  one-cycle strobe per pixel (25 MHz rate)
- frame_start  in  1  pulse between frames (screenEnd)
- line_start  in  1  pulse at start of horizontal blanking before row `line_y`
- line_y  in  10  pixel row about to be drawn
- pixel_x  in  10  current pixel column
- active  in  1  visible region
- snake_len  in  $clog2(MAX_LEN+1)  valid segments; slot 0 is the head
- x_values  in  MAX_LEN*COORD_W  segment columns, slot i at [i*COORD_W +: COORD_W]
- y_values  in  MAX_LEN*COORD_W  segment rows, same packing
- food_x, food_y  in  COORD_W each  food tile
- bg_color  in  12  background colour from palette RAM
- color_out  out  12  registered pixel colour
- busy  out  1  scan in progress
- overrun  out  1  sticky: line_start arrived during a scan

## Operation
- Snapshot: on frame_start, latch snake_len (clamped to MAX_LEN), x_values, y_values, food_x, food_y. All rendering in the frame uses the snapshot, so there is no mid-frame tearing. If frame_start and line_start coincide, the snapshot is taken first and the scan uses the new values.
- FSM: IDLE, DIV, SCAN, COMMIT.
  - IDLE → DIV on line_start: load d = line_y − BOARD_Y0. If line_y < BOARD_Y0, set row_valid=0 and go to COMMIT.
  - DIV: repeated subtraction of TILE_SIZE, one per cycle, giving tile_row and row_off.
    - Row is valid iff tile_row < GRID_H and row_off < BOX_SIZE.
    - If invalid, go to COMMIT. If valid, go to SCAN with idx=0.
  - SCAN: one slot per cycle. If y[idx]==tile_row and x[idx] < GRID_W, set mask_next[x[idx]]. If idx==0, also set head_next[x[idx]]. Exit to COMMIT after idx==len−1; len==0 exits immediately.
  - COMMIT, one cycle:
    - mask_cur ← mask_next, head_cur ← head_next, food_col_cur ← food_x if food_y==tile_row, else none. If row_valid=0, all three are cleared.
    - Clear mask_next/head_next, then return to IDLE.
- line_start in DIV/SCAN: abort, set overrun, go to COMMIT with cleared masks (no snake on that line), then start the new line next cycle.
- Column tracking: on pix_en with pixel_x==BOARD_X0, col←0, off←0. Each later pix_en increments off; at TILE_SIZE−1, off←0 and col++. in_col = (col < GRID_W) && (off < BOX_SIZE) && (pixel_x ≥ BOARD_X0).
- Priority: head (12'h0F0) > body (12'h080) > food (12'hF00) > bg_color. A head drawn over a self-overlapping body tile shows the head colour.
- color_out = active ? selected : 0.

## Timing
- Reset values:
  - outputs: color_out=0, busy=0, overrun=0
  - state: IDLE; all masks cleared.
- color_out latency: 1 clk after pixel_x/active/bg_color.
- busy is high in DIV and SCAN.
- Worst-case scan: GRID_H+1 (DIV) + MAX_LEN (SCAN) + 1 (COMMIT) cycles. This is 110 at defaults, well inside 160 px × 4 = 640 cycles of blanking.
- overrun is cleared only by reset.
- Reset asserted mid-scan: immediate return to IDLE with masks cleared.

## Structure
- Package snake_render_pkg: state enum, colour constants (HEAD/BODY/FOOD), width helper functions.
- Sub-module tile_divider: sequential subtract-and-count divider with start/done handshake, used for the row calculation.
- Row masks are GRID_W-bit registers; no RAM.

## Test plan
- Reset, then one frame with snake_len=0 and food off-board → every active pixel = bg_color; color_out=0 during blanking.
- len=3, segments (2,1),(1,1),(0,1) → pixel (144..183, 96..135) = 12'h0F0; (96..135, 96..135) = 12'h080; gap pixels x=184..191 show bg.
- Overlap: slot 0 and slot 2 both at (3,3) → tile (3,3) = head colour.
- Coordinates change mid-frame (without frame_start) → rendering unchanged until the next frame_start.
- line_start issued 20 cycles after the previous one, with len=100 → overrun=1, that line shows no snake, and the following line renders correctly.
- x=8 (≥GRID_W) segment, and snake_len=120 (clamped to 100) → out-of-range segment ignored, no mask corruption, busy ≤ 110 cycles.
